mem_port_arbiter: RTL

- Round-robin arbiter and sequencer for the node's single shared data-memory port.
- Requesters include the winner policy, the Q-value update and the neighbour-table fetch.
- Serialises one read or write transaction at a time and returns read data with a one-cycle ack pulse.
- Sits between the policy/learning FSMs and the memory array.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer for the shared data-memory port.
// Define ARB_LOCK_EN to add the req_lock port and bounded back-to-back grant locking.
module mem_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_LOCK     = 8
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock,
`endif
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_LOCK < 1) begin : g_cfg_err
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state, next;
  logic [PW-1:0] ptr, own, rr, win, k;
  logic [1:0] lat_cnt;
  logic last;

  assign last = lat_cnt == LAT_LAST;
  assign ack  = state == DONE ? grant : '0;
  assign busy = state != IDLE;

  // Scan from ptr+NUM_REQ down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    rr = ptr;
    k  = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) rr = k;
    end
  end

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt;
  logic lock_pend, lock_take;

  // lock_cnt counts grants in the current locked run, including the first one.
  assign lock_take = lock_pend && req[ptr];
  assign win = lock_take ? ptr : rr;

  always_ff @(posedge clock)
    if (!nreset) begin
      lock_cnt  <= '0;
      lock_pend <= 1'b0;
    end else begin
      lock_pend <= state == DONE && req_lock[own] && lock_cnt < CW'(MAX_LOCK);
      if (state == IDLE && |req) lock_cnt <= lock_take ? lock_cnt + 1'b1 : CW'(1);
    end
`else
  assign win = rr;
`endif

  always_comb
    next = state == IDLE   ? (|req ? ACCESS : IDLE) :
           state == ACCESS ? (mem_we ? DONE : WAIT) :
           state == WAIT   ? (last ? DONE : WAIT) : IDLE;

  always_ff @(posedge clock)
    if (!nreset) begin
      state     <= IDLE;
      grant     <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      ptr       <= PW'(NUM_REQ - 1);
      own       <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && |req) begin
        grant     <= NUM_REQ'(1) << win;
        own       <= win;
        mem_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
        mem_we    <= req_we[win];
      end
      if (state == ACCESS) begin
        mem_we  <= 1'b0;
        lat_cnt <= '0;
      end
      if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
        if (last) rdata <= mem_rdata;
      end
      if (state == DONE) begin
        ptr   <= own;
        grant <= '0;
      end
    end
endmodule
